// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, talks req/ready to instruction memory, fills IF/ID.
// Optional 1-entry skid buffer for stalled-but-completed fetches is enabled by defining FETCH_SKID_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_next,
  input  logic        id_flush,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        fetch_busy,
  output logic        dbg_state
);

  // Handshake: a transfer happens on any cycle with imem_req && imem_ready; once raised,
  // imem_req/imem_addr hold until that cycle, and a request is never withdrawn.
  typedef enum logic {
    S_FETCH = 1'b0,
    S_KILL  = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] redirect_pc, redirect_nxt;
  logic [31:0] inst_nxt, ipc_nxt, ipc4_nxt;
  logic        ivalid_nxt;
  logic        waiting;
  logic        accept;
  logic [31:0] target;
  logic        skid_full;
  logic        unused_bits;

`ifdef FETCH_SKID_EN
  logic        skid_full_nxt;
  logic [31:0] skid_inst, skid_inst_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
`else
  assign skid_full = 1'b0;
`endif

  assign target      = {pc_next[31:2], 2'b00};
  assign unused_bits = ^pc_next[1:0];
  assign dbg_state   = state;

  always_comb begin
    // Outputs depend on state/registers only (plus reset gating), never on imem_ready.
    imem_req   = rst && ((state == S_KILL) || !skid_full);
    imem_addr  = {pc[31:2], 2'b00};
    fetch_busy = (state == S_KILL) || waiting;
    accept     = imem_req && imem_ready;

    state_nxt    = state;
    pc_nxt       = pc;
    redirect_nxt = redirect_pc;
    inst_nxt     = if_id_inst;
    ipc_nxt      = if_id_pc;
    ipc4_nxt     = if_id_pc4;
    ivalid_nxt   = if_id_valid;
`ifdef FETCH_SKID_EN
    skid_full_nxt = skid_full;
    skid_inst_nxt = skid_inst;
    skid_pc_nxt   = skid_pc;
`endif

    case (state)
      S_KILL: begin
        ivalid_nxt = 1'b0;
        if (id_flush) redirect_nxt = target;
        if (imem_ready) begin
          pc_nxt    = id_flush ? target : redirect_pc;
          state_nxt = S_FETCH;
        end
      end
      default: begin
        if (id_flush) begin
          ivalid_nxt = 1'b0;
`ifdef FETCH_SKID_EN
          skid_full_nxt = 1'b0;
`endif
          // With no request in flight (or one finishing now) the target is taken directly.
          if (accept || !imem_req) begin
            pc_nxt = target;
          end else begin
            redirect_nxt = target;
            state_nxt    = S_KILL;
          end
        end else if (!stall) begin
          if (skid_full) begin
`ifdef FETCH_SKID_EN
            inst_nxt      = skid_inst;
            ipc_nxt       = skid_pc;
            ipc4_nxt      = skid_pc + 32'd4;
            ivalid_nxt    = 1'b1;
            skid_full_nxt = 1'b0;
`endif
          end else if (accept) begin
            inst_nxt   = imem_rdata;
            ipc_nxt    = pc;
            ipc4_nxt   = pc + 32'd4;
            ivalid_nxt = 1'b1;
            pc_nxt     = target;
          end else begin
            ivalid_nxt = 1'b0;
          end
        end else if (accept) begin
`ifdef FETCH_SKID_EN
          skid_full_nxt = 1'b1;
          skid_inst_nxt = imem_rdata;
          skid_pc_nxt   = pc;
          pc_nxt        = target;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
      if_id_inst  <= 32'h0;
      if_id_pc    <= 32'h0;
      if_id_pc4   <= 32'h0;
      if_id_valid <= 1'b0;
      waiting     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      redirect_pc <= redirect_nxt;
      if_id_inst  <= inst_nxt;
      if_id_pc    <= ipc_nxt;
      if_id_pc4   <= ipc4_nxt;
      if_id_valid <= ivalid_nxt;
      waiting     <= imem_req && !imem_ready;
    end
  end

`ifdef FETCH_SKID_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_full <= 1'b0;
      skid_inst <= 32'h0;
      skid_pc   <= 32'h0;
    end else begin
      skid_full <= skid_full_nxt;
      skid_inst <= skid_inst_nxt;
      skid_pc   <= skid_pc_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic, checked against a cycle model
// built from the fetch rules (PC, pending redirect, skid as a queue, expected IF/ID contents).
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_next;
  logic        id_flush, stall;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_inst, if_id_pc, if_id_pc4;
  logic        if_id_valid, fetch_busy, dbg_state;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .pc_next(pc_next), .id_flush(id_flush), .stall(stall),
    .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .if_id_inst(if_id_inst), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fetch_busy(fetch_busy),
    .dbg_state(dbg_state)
  );

  // reference model
  logic [31:0] m_pc, m_redir;
  bit          m_kill, m_wait;
  logic [63:0] m_skid[$];
  logic [31:0] e_inst, e_pc, e_pc4;
  logic        e_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_redir = RESET_PC; m_kill = 0; m_wait = 0;
    m_skid.delete();
    e_inst = 32'h0; e_pc = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
  endtask

  // One clock: drive inputs, check combinational outputs mid-cycle, advance model, check registers.
  task automatic step(input bit fl, input bit st, input bit rd, input logic [31:0] nxt);
    logic [31:0] rdata, tgt;
    bit req, acc;
    rdata = $urandom;
    id_flush = fl; stall = st; imem_ready = rd; imem_rdata = rdata; pc_next = nxt;
    @(negedge clk);
    req = m_kill || (m_skid.size() == 0);
    chk("pc", pc, m_pc);
    chk1("imem_req", imem_req, req);
    chk("imem_addr", imem_addr, m_pc);
    chk1("fetch_busy", fetch_busy, m_kill || m_wait);
    chk1("dbg_state", dbg_state, m_kill);
    tgt = {nxt[31:2], 2'b00};
    acc = req && rd;
    if (m_kill) begin
      e_valid = 1'b0;
      if (fl) m_redir = tgt;
      if (rd) begin
        m_pc = m_redir;
        m_kill = 0;
      end
    end else if (fl) begin
      e_valid = 1'b0;
      m_skid.delete();
      if (acc || !req) m_pc = tgt;
      else begin
        m_kill = 1;
        m_redir = tgt;
      end
    end else if (!st) begin
      if (m_skid.size() != 0) begin
        {e_inst, e_pc} = m_skid.pop_front();
        e_pc4 = e_pc + 32'd4;
        e_valid = 1'b1;
      end else if (acc) begin
        e_inst = rdata; e_pc = m_pc; e_pc4 = m_pc + 32'd4; e_valid = 1'b1;
        m_pc = tgt;
      end else begin
        e_valid = 1'b0;
      end
    end else if (acc) begin
`ifdef FETCH_SKID_EN
      m_skid.push_back({rdata, m_pc});
      m_pc = tgt;
`endif
    end
    m_wait = req && !rd;
    @(posedge clk);
    #1;
    chk("pc_after", pc, m_pc);
    chk1("if_id_valid", if_id_valid, e_valid);
    if (e_valid) begin
      chk("if_id_inst", if_id_inst, e_inst);
      chk("if_id_pc", if_id_pc, e_pc);
      chk("if_id_pc4", if_id_pc4, e_pc4);
    end
  endtask

  initial begin
    id_flush = 0; stall = 0; imem_ready = 0; imem_rdata = 0; pc_next = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pc", pc, RESET_PC);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", if_id_valid, 1'b0);
    chk("rst_inst", if_id_inst, 32'h0);
    chk1("rst_busy", fetch_busy, 1'b0);
    rst = 1;

    // zero-wait sequential fetch: 0, 4, 8
    step(0, 0, 1, m_pc + 32'd4);
    chk("seq_pc0", if_id_pc, 32'h0);
    step(0, 0, 1, m_pc + 32'd4);
    step(0, 0, 1, m_pc + 32'd4);
    chk("seq_pc8", if_id_pc, 32'h8);

    // three wait cycles at 0x40
    step(0, 0, 1, 32'h40);
    repeat (3) begin
      step(0, 0, 0, m_pc + 32'd4);
      chk("wait_addr", imem_addr, 32'h40);
    end
    step(0, 0, 1, m_pc + 32'd4);
    chk("wait_pc", if_id_pc, 32'h40);
    chk("wait_pc4", if_id_pc4, 32'h44);
    chk1("wait_valid", if_id_valid, 1'b1);

    // redirect to 0x100 while waiting at 0x40
    step(0, 0, 1, 32'h40);
    step(1, 0, 0, 32'h100);
    step(0, 0, 0, m_pc + 32'd4);
    step(0, 0, 1, m_pc + 32'd4);
    chk("kill_pc", pc, 32'h100);
    chk1("kill_valid", if_id_valid, 1'b0);
    step(0, 0, 1, m_pc + 32'd4);
    chk("kill_target", if_id_pc, 32'h100);

    // stall coincident with a completing fetch at 0x20, held 2 cycles
    step(0, 0, 1, 32'h20);
    step(0, 1, 1, m_pc + 32'd4);
    step(0, 1, 1, m_pc + 32'd4);
    step(0, 0, 1, m_pc + 32'd4);
    chk("stall_pc", if_id_pc, 32'h20);
    chk1("stall_valid", if_id_valid, 1'b1);
    step(0, 0, 1, m_pc + 32'd4);

    // PC+4 wrap
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 1, 32'h0);
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc4, 32'h0);

    // async reset mid-wait
    step(0, 0, 1, 32'h80);
    step(0, 0, 0, m_pc + 32'd4);
    step(0, 0, 0, m_pc + 32'd4);
    #1 rst = 0;
    #1;
    model_reset();
    chk("arst_pc", pc, RESET_PC);
    chk1("arst_req", imem_req, 1'b0);
    chk1("arst_busy", fetch_busy, 1'b0);
    chk1("arst_valid", if_id_valid, 1'b0);
    chk("arst_inst", if_id_inst, 32'h0);
    chk("arst_ifpc", if_id_pc, 32'h0);
    chk("arst_pc4", if_id_pc4, 32'h0);
    rst = 1;
    step(0, 0, 1, m_pc + 32'd4);
    chk("arst_first", if_id_pc, RESET_PC);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit fl, st, rd;
      logic [31:0] nxt;
      fl = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 4) == 0) nxt = $urandom;
      else nxt = m_pc + 32'd4;
      step(fl, st, rd, nxt);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
